// File: rtl/muldiv_unit_if.sv
// Handshake and data bundle between the EX-stage decoder and the iterative
// multiply-divide unit.
interface muldiv_unit_if #(
    parameter int XLEN = 32
) ();
    logic            valid;
    logic [2:0]      fun3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            result_valid;
    logic [XLEN-1:0] result;

    modport master (
        output valid, fun3, op_a, op_b, flush,
        input  stall, busy, result_valid, result
    );

    modport slave (
        input  valid, fun3, op_a, op_b, flush,
        output stall, busy, result_valid, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply-divide unit: shift-add multiplier and restoring
// divider retiring one bit per cycle while holding the pipeline via stall.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input logic          clk,
    input logic          rst_n,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     count;
    logic [2:0]        op;
    logic [XLEN-1:0]   opnd;
    logic [2*XLEN-1:0] acc;
    logic              negate;
    logic              busy_q;
    logic              result_valid_q;
    logic [XLEN-1:0]   result_q;

    logic              accept;
    logic              is_div;
    logic              a_signed;
    logic              b_signed;
    logic              sign_a;
    logic              sign_b;
    logic              div_zero;
    logic              div_ovf;
    logic              fast;
    logic              last;
    logic              negate_in;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [XLEN-1:0]   fast_result;

    logic [XLEN:0]     sum;
    logic [XLEN:0]     trial;
    logic [XLEN:0]     diff;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   div_sel;
    logic [XLEN-1:0]   final_result;

    // Operand decode: signedness, magnitudes and the two divide special cases.
    always_comb begin
        accept    = (state == IDLE) && bus.valid && !bus.flush;
        is_div    = bus.fun3[2];
        a_signed  = is_div ? !bus.fun3[0] : (bus.fun3[1:0] == 2'b01 || bus.fun3[1:0] == 2'b10);
        b_signed  = is_div ? !bus.fun3[0] : (bus.fun3[1:0] == 2'b01);
        sign_a    = a_signed && bus.op_a[XLEN-1];
        sign_b    = b_signed && bus.op_b[XLEN-1];
        mag_a     = sign_a ? -bus.op_a : bus.op_a;
        mag_b     = sign_b ? -bus.op_b : bus.op_b;
        div_zero  = is_div && (bus.op_b == '0);
        div_ovf   = is_div && !bus.fun3[0] && (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);
        fast      = div_zero || div_ovf;
        negate_in = (is_div && bus.fun3[1]) ? sign_a : (sign_a ^ sign_b);
        if (div_zero) fast_result = bus.fun3[1] ? bus.op_a : '1;
        else          fast_result = bus.fun3[1] ? '0 : bus.op_a;
    end

    // One iteration step; acc holds {partial, multiplier} or {remainder, quotient}.
    always_comb begin
        sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
        trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff  = trial - {1'b0, opnd};
        if (!op[2])          acc_next = {sum, acc[XLEN-1:1]};
        else if (!diff[XLEN]) acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else                  acc_next = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        prod_signed = negate ? -acc_next : acc_next;
        div_sel     = op[1] ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
        if (!op[2]) final_result = (op[1:0] == 2'b00) ? prod_signed[XLEN-1:0] : prod_signed[2*XLEN-1:XLEN];
        else        final_result = negate ? -div_sel : div_sel;
        last = (count == CW'(XLEN-1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = fast ? DONE : CALC;
            CALC:    if (bus.flush) state_next = IDLE;
                     else if (last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count          <= '0;
            op             <= '0;
            opnd           <= '0;
            acc            <= '0;
            negate         <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            result_q       <= '0;
        end else begin
            busy_q         <= (state_next != IDLE);
            result_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    count <= '0;
                    if (accept) begin
                        op     <= bus.fun3;
                        negate <= negate_in;
                        opnd   <= is_div ? mag_b : mag_a;
                        acc    <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                        if (fast) begin
                            result_q       <= fast_result;
                            result_valid_q <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (bus.flush) begin
                        count <= '0;
                    end else begin
                        acc   <= acc_next;
                        count <= count + CW'(1);
                        if (last) begin
                            result_q       <= final_result;
                            result_valid_q <= 1'b1;
                        end
                    end
                end
                default: count <= '0;
            endcase
        end
    end

    assign bus.stall        = rst_n && (accept || (state == CALC));
    assign bus.busy         = busy_q;
    assign bus.result_valid = result_valid_q;
    assign bus.result       = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases plus randomized ops
// compared every cycle against a cycle-level behavioural model.
module tb_muldiv_unit;
    localparam int XLEN = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    muldiv_unit_if #(.XLEN(XLEN)) bus ();

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RV32M result computed with plain 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = '0;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    function automatic logic is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 0) || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Behavioural model: edges remaining until the result, plus the DONE cycle.
    int          m_left;
    logic        m_done_cycle;
    logic        m_rv;
    logic [31:0] m_result;
    logic [31:0] m_pending;
    logic        model_ready;

    initial begin
        m_left = 0; m_done_cycle = 1'b0; m_rv = 1'b0; m_result = '0; m_pending = '0; model_ready = 1'b0;
    end

    always @(posedge clk) begin
        m_rv = 1'b0;
        if (!rst_n) begin
            m_left       = 0;
            m_done_cycle = 1'b0;
            m_result     = '0;
            model_ready  = 1'b1;
        end else if (m_done_cycle) begin
            m_done_cycle = 1'b0;
        end else if (m_left > 0) begin
            if (bus.flush) begin
                m_left = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_result = m_pending; m_rv = 1'b1; m_done_cycle = 1'b1;
                end
            end
        end else if (bus.valid && !bus.flush) begin
            if (is_fast(bus.fun3, bus.op_a, bus.op_b)) begin
                m_result = ref_result(bus.fun3, bus.op_a, bus.op_b); m_rv = 1'b1; m_done_cycle = 1'b1;
            end else begin
                m_pending = ref_result(bus.fun3, bus.op_a, bus.op_b); m_left = XLEN;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ready) begin
            check_output("stall", 64'(bus.stall),
                64'(rst_n && ((m_left == 0 && !m_done_cycle && bus.valid && !bus.flush) || m_left > 0)));
            check_output("busy", 64'(bus.busy), 64'((m_left > 0) || m_done_cycle));
            check_output("result_valid", 64'(bus.result_valid), 64'(m_rv));
            check_output("result", 64'(bus.result), 64'(m_result));
        end
    end

    task automatic apply_stimulus(input string name, input logic [2:0] f, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] exp_res,
                                  input int exp_lat, input int flush_at);
        int n;
        int lat;
        int stall_cnt;
        n = 0;
        while (bus.busy !== 1'b0 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check_output({name, " idle"}, 64'(bus.busy), 64'(0));
        bus.fun3 = f; bus.op_a = a; bus.op_b = b; bus.valid = 1'b1; bus.flush = 1'b0;
        #1;
        stall_cnt = (bus.stall === 1'b1) ? 1 : 0;
        @(posedge clk); #1;
        bus.valid = 1'b0;
        if (flush_at > 0) begin
            repeat (flush_at - 1) begin @(posedge clk); #1; end
            bus.flush = 1'b1;
            @(posedge clk); #1;
            bus.flush = 1'b0;
            check_output({name, " flush busy"}, 64'(bus.busy), 64'(0));
            check_output({name, " flush result_valid"}, 64'(bus.result_valid), 64'(0));
            check_output({name, " flush result"}, 64'(bus.result), 64'(exp_res));
            return;
        end
        lat = 1;
        while (bus.result_valid !== 1'b1 && lat < 100) begin
            if (bus.stall === 1'b1) stall_cnt++;
            bus.fun3 = 3'($urandom); bus.op_a = $urandom; bus.op_b = $urandom;
            @(posedge clk); #1; lat++;
        end
        if (bus.stall === 1'b1) stall_cnt++;
        check_output({name, " latency"}, 64'(lat), 64'(exp_lat));
        check_output({name, " stall cycles"}, 64'(stall_cnt), 64'(exp_lat));
        check_output({name, " result"}, 64'(bus.result), 64'(exp_res));
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'h1;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired before summary");
        $fatal(1, "[TB] timeout");
    end

    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    int          fl;

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0;
        bus.valid = 1'b0; bus.flush = 1'b0; bus.fun3 = '0; bus.op_a = '0; bus.op_b = '0;

        check_output("model MUL", 64'(ref_result(3'd0, 32'd7, 32'hFFFFFFFD)), 64'hFFFFFFEB);
        check_output("model MULH", 64'(ref_result(3'd1, 32'h80000000, 32'h80000000)), 64'h40000000);
        check_output("model MULHU", 64'(ref_result(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF)), 64'hFFFFFFFE);
        check_output("model MULHSU", 64'(ref_result(3'd2, 32'hFFFFFFFF, 32'd2)), 64'hFFFFFFFF);
        check_output("model DIV", 64'(ref_result(3'd4, 32'hFFFFFFF9, 32'd2)), 64'hFFFFFFFD);
        check_output("model REM ovf", 64'(ref_result(3'd6, 32'h80000000, 32'hFFFFFFFF)), 64'h0);

        repeat (2) @(posedge clk);
        #1;
        check_output("reset busy", 64'(bus.busy), 64'(0));
        check_output("reset result", 64'(bus.result), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        apply_stimulus("MUL", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 0);
        apply_stimulus("MULH", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33, 0);
        apply_stimulus("MULHU", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0);
        apply_stimulus("MULHSU", 3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33, 0);
        apply_stimulus("DIV", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 0);
        apply_stimulus("REM", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 0);
        apply_stimulus("DIVU", 3'd5, 32'd100, 32'd7, 32'd14, 33, 0);
        apply_stimulus("REMU", 3'd7, 32'd100, 32'd7, 32'd2, 33, 0);

        apply_stimulus("flush DIVU", 3'd5, 32'd1000, 32'd3, 32'd2, 0, 10);
        apply_stimulus("MUL after flush", 3'd0, 32'd3, 32'd4, 32'd12, 33, 0);

        // Reset on the 5th CALC cycle of a MUL.
        bus.fun3 = 3'd0; bus.op_a = 32'd5; bus.op_b = 32'd6; bus.valid = 1'b1;
        @(posedge clk); #1;
        bus.valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check_output("reset mid-op stall low", 64'(bus.stall), 64'(0));
        @(posedge clk); #1;
        check_output("reset mid-op busy", 64'(bus.busy), 64'(0));
        check_output("reset mid-op result", 64'(bus.result), 64'(0));
        check_output("reset mid-op stall", 64'(bus.stall), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        bus.valid = 1'b1; bus.flush = 1'b1; bus.fun3 = 3'd0;
        repeat (3) begin
            #1;
            check_output("valid+flush stall", 64'(bus.stall), 64'(0));
            @(posedge clk); #1;
            check_output("valid+flush busy", 64'(bus.busy), 64'(0));
        end
        bus.valid = 1'b0; bus.flush = 1'b0;

        apply_stimulus("DIV by 0", 3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 0);
        apply_stimulus("REM by 0", 3'd6, 32'd5, 32'd0, 32'd5, 1, 0);
        apply_stimulus("DIV ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
        apply_stimulus("REM ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, 0);

        for (int i = 0; i < 150; i++) begin
            f = 3'($urandom);
            a = pick_operand();
            b = pick_operand();
            fl = 0;
            if (!is_fast(f, a, b) && $urandom_range(0, 9) == 0) fl = $urandom_range(1, XLEN);
            if (fl > 0) apply_stimulus("rand flush", f, a, b, m_result, 0, fl);
            else        apply_stimulus("rand", f, a, b, ref_result(f, a, b),
                                       is_fast(f, a, b) ? 1 : XLEN + 1, 0);
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk); #1;
                bus.valid = 1'b1; bus.flush = 1'b1;
                @(posedge clk); #1;
                bus.valid = 1'b0; bus.flush = 1'b0;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M/RV64M multiply–divide unit for the EX stage of the 5-stage pipeline, widening the ALU-control decode from ALU-only ops to the M extension. Sits beside the single-cycle ALU. Accepts an operation when the decoder flags an M-type R-instruction (funct7 = 0000001), then holds the pipeline via `stall` while a shift-add multiplier or restoring divider iterates one bit per cycle. Presents a one-cycle `result_valid` pulse with the XLEN-bit result.

## Interface
- `XLEN`, default 32: operand and result width. Must be a power of two, at least 8.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `valid`  in  1  an M-type op is in EX. Sampled only in IDLE.
- `fun3`  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  in  XLEN  rs1 value (multiplicand / dividend).
- `op_b`  in  XLEN  rs2 value (multiplier / divisor).
- `flush`  in  1  abort the current op (branch mispredict or trap).
- `stall`  out  1  hold IF/ID/EX. Combinational: (state==IDLE && valid && !flush) || state==CALC.
- `busy`  out  1  registered; high in CALC or DONE.
- `result_valid`  out  1  registered one-cycle pulse in DONE.
- `result`  out  XLEN  registered; holds its value until the next DONE.

## Operation
- **State machine:** IDLE, CALC, DONE. A 2-bit state register plus an iteration counter of $clog2(XLEN)+1 bits.
- **IDLE**
  - valid && !flush at a clock edge: latch the op. Go to CALC with counter = 0, or straight to DONE on the fast path.
  - Latching captures operand magnitudes, the sign flags and the negate-result flag.
- **Sign rules**
  - op_a is treated as signed for MULH, MULHSU, DIV, REM.
  - op_b is treated as signed for MULH, DIV, REM.
  - All other operand/op combinations are unsigned.
- **Multiply:** 2·XLEN product register, shift-add, one multiplier bit per CALC cycle.
  - MUL returns product[XLEN-1:0].
  - MULH, MULHSU, MULHU return product[2XLEN-1:XLEN].
  - The product is negated in 2·XLEN width when exactly one signed operand is negative.
- **Divide:** restoring, one quotient bit per CALC cycle.
  - Quotient is negated when the operand signs differ (DIV).
  - Remainder takes the sign of the dividend (REM).
- **Fast path** (IDLE → DONE, no CALC):
  - Divisor == 0: quotient = all ones, remainder = op_a.
  - Signed overflow (op_a == 1 followed by XLEN-1 zeros, op_b == all ones, DIV/REM): quotient = op_a, remainder = 0.
- **CALC:** the counter increments each cycle. At counter == XLEN-1, sign-correct the result, write `result` and go to DONE.
- **DONE:** `result_valid` = 1 and `stall` = 0, so EX/MEM captures `result` this cycle. Unconditionally return to IDLE. `valid` is not sampled in DONE.
- **flush**
  - In CALC: go to IDLE at the next edge. No `result_valid`; `result` is unchanged.
  - In DONE: no effect (the result has already been consumed).
  - Together with valid in IDLE: flush wins and nothing is accepted.
- **Reset**
  - rst_n low at an edge, in any state (including mid-CALC): state = IDLE, counter = 0, result = 0, result_valid = 0, busy = 0.
  - `stall` is forced 0 while rst_n is low.

## Timing
- **Accept** is edge T0 (IDLE, valid=1). `busy` rises after T0.
- **Iterative ops:**
  - CALC occupies XLEN cycles.
  - `result_valid` and `result` are valid in the cycle after edge T0+XLEN.
  - Total latency from accept to result is XLEN+1 cycles (33 for XLEN=32).
  - `stall` is high for XLEN+1 cycles: the accept cycle plus XLEN CALC cycles.
- **Fast path:** `result_valid` in the cycle after T0 (latency 1). `stall` is high for 1 cycle.
- **Back-to-back ops:** the earliest next accept is the cycle after DONE, so there is one idle cycle between ops.

## Test plan
1. **Iterative MUL, XLEN=32.** MUL 7 × 0xFFFFFFFD → `result` = 0xFFFFFFEB. `stall` high exactly 33 cycles; `result_valid` a single pulse 33 cycles after accept.
2. **High-half multiplies.**
   - MULH 0x80000000 × 0x80000000 → 0x40000000.
   - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
   - MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
3. **Signed and unsigned divide.**
   - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
   - REM 0xFFFFFFF9 / 2 → 0xFFFFFFFF.
   - DIVU 100 / 7 → 14.
   - REMU 100 / 7 → 2.
4. **Fast-path cases, each with `result_valid` the cycle after accept and no CALC.**
   - DIV 5 / 0 → 0xFFFFFFFF.
   - REM 5 / 0 → 5.
   - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
   - REM 0x80000000 / 0xFFFFFFFF → 0.
5. **Flush mid-CALC.** Start DIVU, assert flush on the 10th CALC cycle → IDLE next cycle, no `result_valid`, `result` retains its prior value. A following MUL 3 × 4 → 12 with normal latency.
6. **Reset mid-op.** rst_n low on the 5th CALC cycle of MUL → next cycle state IDLE, `result` = 0, `busy` = 0, `stall` = 0. Also check valid=1 with flush=1 in IDLE → not accepted, `busy` stays 0.
